// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with block-serial refill; optional counters under ICACHE_PERF_CNT_EN
module icache_direct_mapped #(
    parameter int IDX_BITS = 3,
    parameter int TAG_BITS = 25
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int LINES = 1 << IDX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [127:0]        data_q [LINES];

    logic [IDX_BITS-1:0] index;
    logic [TAG_BITS-1:0] addr_tag;
    logic [1:0]          offset;
    logic                hit;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] fill_tag;
    logic                unused_addr_bits;

    assign index            = address[4+IDX_BITS-1:4];
    assign addr_tag         = address[31:4+IDX_BITS];
    assign offset           = address[3:2];
    assign unused_addr_bits = ^address[1:0];

    assign hit         = valid_q[index] && (tag_q[index] == addr_tag);
    assign instruction = data_q[index][{offset, 5'd0} +: 32];

    // The fill target comes from the block address latched on entry to MEM_READ,
    // so a fill finishes correctly even if the CPU moves on mid-refill.
    assign fill_idx = mem_address[IDX_BITS-1:0];
    assign fill_tag = mem_address[27:IDX_BITS];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (read && !hit) state_d = MEM_READ;
            MEM_READ: if (!mem_busywait) state_d = UPDATE;
            UPDATE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign mem_read = (state_q == MEM_READ);
    assign busywait = (state_q != IDLE) || (read && !hit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_address <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == MEM_READ) begin
                mem_address <= address[31:4];
            end
            if (state_q == UPDATE) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits alone gate hits.
    always_ff @(posedge clock) begin
        if (state_q == UPDATE) begin
            data_q[fill_idx] <= mem_readdata;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state_q == IDLE && read && hit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (state_q == IDLE && state_d == MEM_READ && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - directed self-checking bench for icache_direct_mapped with a serial byte memory model
module tb_icache_direct_mapped;

    logic         clock;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;

    icache_direct_mapped dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: block 0 bytes 0..3 fixed, every other byte = addr[7:0]^addr[15:8]^0x5A
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h37;
            32'h1:   return 8'h40;
            32'h2:   return 8'h1f;
            32'h3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    logic [3:0] byte_cnt;
    assign mem_busywait = !(mem_read && byte_cnt == 4'd15);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= 4'd0;
        end else if (mem_read) begin
            mem_readdata[{byte_cnt, 3'b000} +: 8] <= mem_byte({mem_address, byte_cnt});
            byte_cnt <= byte_cnt + 4'd1;
        end
    end

    // Presents a fetch at a negedge and samples every cycle until busywait drops.
    task automatic do_fetch(input logic [31:0] a, output int stall, output int mr_cycles,
                            output logic addr_bad, output logic [31:0] instr);
        stall     = 0;
        mr_cycles = 0;
        addr_bad  = 1'b0;
        instr     = 32'h0;
        @(negedge clock);
        read    = 1'b1;
        address = a;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (mem_read) begin
                mr_cycles++;
                if (mem_address !== a[31:4]) addr_bad = 1'b1;
            end
            if (!busywait) begin
                instr = instruction;
                break;
            end
            stall++;
            @(negedge clock);
        end
    endtask

    task automatic check_fetch(input string name, input logic [31:0] a, input int exp_stall,
                               input logic [31:0] exp_instr);
        int stall, mrc;
        logic bad;
        logic [31:0] instr;
        do_fetch(a, stall, mrc, bad, instr);
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL %s stall: got %0d expected %0d", name, stall, exp_stall);
        end
        checks++;
        if (instr !== exp_instr) begin
            errors++;
            $display("FAIL %s instruction: got %08h expected %08h", name, instr, exp_instr);
        end
        checks++;
        if (mrc !== ((exp_stall == 0) ? 0 : 16) || bad !== 1'b0) begin
            errors++;
            $display("FAIL %s mem_read: got %0d cycles addr_bad=%0b expected %0d cycles addr_bad=0",
                     name, mrc, bad, (exp_stall == 0) ? 0 : 16);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        read    = 1'b0;
        address = 32'h0;
        @(negedge clock);
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_address !== 28'h0 || busywait !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got mem_read=%0b mem_address=%07h busywait=%0b expected 0 0 0",
                     mem_read, mem_address, busywait);
        end
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset counters: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        check_fetch("cold_miss", 32'h0000_0000, 18, 32'h001F_4037);
    endtask

    task automatic test_warm_hit();
        check_fetch("warm_hit_0", 32'h0000_0000, 0, 32'h001F_4037);
        check_fetch("warm_hit_4", 32'h0000_0004, 0, 32'h5D5C_5F5E);
        check_fetch("warm_hit_8", 32'h0000_0008, 0, 32'h5150_5352);
        @(negedge clock);
        read = 1'b0;
        #1;
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_count !== 32'd4 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL counters: got hit=%0d miss=%0d expected 4 1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_conflict();
        check_fetch("conflict_80", 32'h0000_0080, 18, 32'hD9D8_DBDA);
        check_fetch("conflict_00", 32'h0000_0000, 18, 32'h001F_4037);
    endtask

    task automatic test_back_to_back();
        check_fetch("b2b_20", 32'h0000_0020, 18, 32'h7978_7B7A);
        check_fetch("b2b_30", 32'h0000_0030, 18, 32'h6968_6B6A);
    endtask

    task automatic test_abandoned();
        bit got;
        check_fetch("abandon_evict", 32'h0000_0080, 18, 32'hD9D8_DBDA);
        @(negedge clock);
        read    = 1'b1;
        address = 32'h0000_0000;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_read) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        @(negedge clock);
        read    = 1'b0;
        address = 32'h0000_0010;
        #1;
        checks++;
        if (!got || mem_read !== 1'b1 || mem_address !== 28'h0) begin
            errors++;
            $display("FAIL abandon_hold: got started=%0b mem_read=%0b mem_address=%07h expected 1 1 0000000",
                     got, mem_read, mem_address);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (!busywait && !mem_read) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL abandon_complete: got busy after 40 cycles expected idle");
        end
        check_fetch("abandon_hit_00", 32'h0000_0000, 0, 32'h001F_4037);
        check_fetch("abandon_miss_10", 32'h0000_0010, 18, 32'h4948_4B4A);
    endtask

    task automatic test_reset_mid_fill();
        int n;
        @(negedge clock);
        read    = 1'b1;
        address = 32'h0000_0040;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mem_read) n++;
            if (n == 5) break;
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (n !== 5 || mem_read !== 1'b0 || mem_address !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid_fill: got mr_cycles=%0d mem_read=%0b mem_address=%07h expected 5 0 0000000",
                     n, mem_read, mem_address);
        end
        @(negedge clock);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        checks++;
        if (busywait !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busywait=%0b mem_read=%0b expected 0 0", busywait, mem_read);
        end
        check_fetch("post_reset_00", 32'h0000_0000, 18, 32'h001F_4037);
        check_fetch("post_reset_40", 32'h0000_0040, 18, 32'h1918_1B1A);
    endtask

    initial begin
        reset   = 1'b1;
        read    = 1'b0;
        address = 32'h0;
        test_reset();
        test_cold_miss();
        test_warm_hit();
        test_conflict();
        test_back_to_back();
        test_abandoned();
        test_reset_mid_fill();
        @(negedge clock);
        read = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
